// File: rtl/exception_sequencer_pkg.sv
// exception_sequencer_pkg
//   Shared definitions for the exception sequencer: the 3-bit FSM state
//   encoding, the interrupt-vector-table entry size, the captured fault
//   context record, and a helper that forms a vector-table entry address.
package exception_sequencer_pkg;

  // FSM state encoding (3-bit).
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FLUSH      = 3'd1;
  localparam logic [2:0] ST_DRAIN      = 3'd2;
  localparam logic [2:0] ST_PUSH_FLAGS = 3'd3;
  localparam logic [2:0] ST_PUSH_EIP   = 3'd4;
  localparam logic [2:0] ST_READ_VEC   = 3'd5;
  localparam logic [2:0] ST_REDIRECT   = 3'd6;
  localparam logic [2:0] ST_SHUTDOWN   = 3'd7;

  // Each vector-table entry is one 32-bit handler address.
  localparam int unsigned VEC_ENTRY_BYTES = 4;
  localparam int unsigned VEC_ENTRY_SHIFT = $clog2(VEC_ENTRY_BYTES);

  // Fault context captured when the exception is accepted.
  typedef struct packed {
    logic [7:0]  vector;
    logic [31:0] eip;
    logic [31:0] eflags;
    logic [31:0] esp;
  } exc_ctx_t;

  // Vector-table entry address; wraps modulo 2^32.
  function automatic logic [31:0] vec_entry_addr(input logic [31:0] base,
                                                 input logic [7:0]  vec);
    return base + ({24'b0, vec} << VEC_ENTRY_SHIFT);
  endfunction

endpackage

// File: rtl/exception_sequencer_capture.sv
// exc_capture_regs
//   Holds the captured fault context (vector, EIP, EFLAGS, ESP) for the
//   duration of one exception sequence.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset (clears all fields)
//     i_load   load enable, one cycle when an exception is accepted
//     i_ctx    context to capture
//     o_ctx    captured context
module exc_capture_regs
  import exception_sequencer_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_load,
  input  exc_ctx_t i_ctx,
  output exc_ctx_t o_ctx
);

  exc_ctx_t r_ctx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ctx <= '0;
    else if (i_load) r_ctx <= i_ctx;
  end

  assign o_ctx = r_ctx;

endmodule

// File: rtl/exception_sequencer.sv
// exception_sequencer
//   Sequences a limit-check fault: flush the pipeline, wait for it to
//   drain, push EFLAGS then EIP onto the stack, fetch the handler address
//   from the vector table and redirect fetch to it.
//   Parameters:
//     IDT_BASE    base address of the 4-byte-per-entry vector table
//     PUSH_BYTES  stack decrement per pushed word
//   Ports:
//     clk, reset                      clock, async active-low reset
//     exc_valid/exc_vector/exc_eip    fault request and its context
//     eflags, esp, pipe_empty         core state inputs
//     mem_valid/we/addr/wdata         memory request (held until mem_ready)
//     mem_ready, mem_rdata            memory response
//     flush, stall_fetch              pipeline control
//     esp_wr, esp_new                 one-cycle stack pointer update
//     redirect_valid, redirect_eip    one-cycle fetch redirect
//     busy, shutdown                  status
//   Build option:
//     DOUBLE_FAULT_EN  a new fault during a stack push or vector read
//                      aborts the transfer and enters SHUTDOWN until reset.
//                      Undefined: such faults are ignored and shutdown=0.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter logic [31:0] IDT_BASE   = 32'h0000_0000,
  parameter int unsigned PUSH_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [7:0]  exc_vector,
  input  logic [31:0] exc_eip,
  input  logic [31:0] eflags,
  input  logic [31:0] esp,
  input  logic        pipe_empty,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        flush,
  output logic        stall_fetch,
  output logic        esp_wr,
  output logic [31:0] esp_new,
  output logic        redirect_valid,
  output logic [31:0] redirect_eip,
  output logic        busy,
  output logic        shutdown
);

  localparam logic [31:0] PUSH_1 = 32'(PUSH_BYTES);
  localparam logic [31:0] PUSH_2 = 32'(2 * PUSH_BYTES);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_esp_wr;
  logic [31:0] r_esp_new;
  logic [31:0] r_vec_word;

  exc_ctx_t    w_ctx_in;
  exc_ctx_t    w_ctx;
  logic        w_load;
  logic        w_mem_state;
  logic        w_abort;
  logic        w_done;

  // Context is captured only on acceptance in IDLE; faults raised while
  // busy never disturb the sequence in flight.
  assign w_load   = (r_state == ST_IDLE) && exc_valid;
  assign w_ctx_in = '{vector: exc_vector, eip: exc_eip, eflags: eflags, esp: esp};

  exc_capture_regs u_cap (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_load),
    .i_ctx   (w_ctx_in),
    .o_ctx   (w_ctx)
  );

  assign w_mem_state = (r_state == ST_PUSH_FLAGS) ||
                       (r_state == ST_PUSH_EIP)   ||
                       (r_state == ST_READ_VEC);

`ifdef DOUBLE_FAULT_EN
  assign w_abort  = w_mem_state && exc_valid;
  assign shutdown = (r_state == ST_SHUTDOWN);
`else
  assign w_abort  = 1'b0;
  assign shutdown = 1'b0;
`endif

  // A transfer completes only with valid and ready together; an abort
  // takes priority so a double fault never produces esp_wr or redirect.
  assign w_done = mem_valid && mem_ready && !w_abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (exc_valid)  w_state_nxt = ST_FLUSH;
      ST_FLUSH:                      w_state_nxt = ST_DRAIN;
      ST_DRAIN:      if (pipe_empty) w_state_nxt = ST_PUSH_FLAGS;
      ST_PUSH_FLAGS: if (w_abort)     w_state_nxt = ST_SHUTDOWN;
                     else if (w_done) w_state_nxt = ST_PUSH_EIP;
      ST_PUSH_EIP:   if (w_abort)     w_state_nxt = ST_SHUTDOWN;
                     else if (w_done) w_state_nxt = ST_READ_VEC;
      ST_READ_VEC:   if (w_abort)     w_state_nxt = ST_SHUTDOWN;
                     else if (w_done) w_state_nxt = ST_REDIRECT;
      ST_REDIRECT:                   w_state_nxt = ST_IDLE;
`ifdef DOUBLE_FAULT_EN
      ST_SHUTDOWN:                   w_state_nxt = ST_SHUTDOWN;
`else
      ST_SHUTDOWN:                   w_state_nxt = ST_IDLE;
`endif
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Memory request is a pure function of state and captured context, so
  // it stays stable while waiting for mem_ready and drops the instant
  // reset forces IDLE.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_PUSH_FLAGS: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_ctx.esp - PUSH_1;
        mem_wdata = w_ctx.eflags;
      end
      ST_PUSH_EIP: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_ctx.esp - PUSH_2;
        mem_wdata = w_ctx.eip;
      end
      ST_READ_VEC: begin
        mem_valid = 1'b1;
        mem_addr  = vec_entry_addr(IDT_BASE, w_ctx.vector);
      end
      default: ;
    endcase
  end

  // Stack pointer update pulses in the cycle after the EIP push lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_esp_wr  <= 1'b0;
      r_esp_new <= '0;
    end else begin
      r_esp_wr <= (r_state == ST_PUSH_EIP) && w_done;
      if ((r_state == ST_PUSH_EIP) && w_done) r_esp_new <= w_ctx.esp - PUSH_2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_vec_word <= '0;
    else if ((r_state == ST_READ_VEC) && w_done)  r_vec_word <= mem_rdata;
  end

  assign esp_wr         = r_esp_wr;
  assign esp_new        = r_esp_new;
  assign redirect_valid = (r_state == ST_REDIRECT);
  assign redirect_eip   = r_vec_word;
  assign flush          = (r_state == ST_FLUSH);
  assign stall_fetch    = (r_state != ST_IDLE);
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference model: each accepted fault expands into a list of three
//   memory transfers (push flags, push eip, read vector) that the DUT must
//   present in order, each held until the responder accepts it.
module tb_exception_sequencer;

  logic        clk, reset;
  logic        exc_valid;
  logic [7:0]  exc_vector;
  logic [31:0] exc_eip, eflags, esp;
  logic        pipe_empty;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        flush, stall_fetch, esp_wr, redirect_valid, busy, shutdown;
  logic [31:0] esp_new, redirect_eip;

  exception_sequencer dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_vector(exc_vector), .exc_eip(exc_eip),
    .eflags(eflags), .esp(esp), .pipe_empty(pipe_empty),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .flush(flush), .stall_fetch(stall_fetch), .esp_wr(esp_wr),
    .esp_new(esp_new), .redirect_valid(redirect_valid),
    .redirect_eip(redirect_eip), .busy(busy), .shutdown(shutdown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases (bench-local, not the DUT encoding).
  localparam int P_IDLE = 0, P_FLUSH = 1, P_DRAIN = 2, P_XFER = 3,
                 P_REDIR = 4, P_SHUT = 5;

  int          n_vec = 0, n_err = 0;
  int          m_ph, m_idx;
  logic [31:0] x_addr [3];
  logic [31:0] x_data [3];
  logic        x_we   [3];
  logic [31:0] m_esp, m_esp_new, m_word;
  logic        m_esp_wr;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [31:0] obs_esp_new, obs_redir;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic xf;
    xf = (m_ph == P_XFER);
    chk("busy",        32'(busy),           32'(m_ph != P_IDLE));
    chk("stall_fetch", 32'(stall_fetch),    32'(m_ph != P_IDLE));
    chk("flush",       32'(flush),          32'(m_ph == P_FLUSH));
    chk("mem_valid",   32'(mem_valid),      32'(xf));
    chk("mem_we",      32'(mem_we),         xf ? 32'(x_we[m_idx]) : 32'd0);
    chk("mem_addr",    mem_addr,            xf ? x_addr[m_idx] : 32'd0);
    chk("mem_wdata",   mem_wdata,           xf ? x_data[m_idx] : 32'd0);
    chk("redirect_valid", 32'(redirect_valid), 32'(m_ph == P_REDIR));
    if (m_ph == P_REDIR) chk("redirect_eip", redirect_eip, m_word);
    chk("esp_wr",      32'(esp_wr),         32'(m_esp_wr));
    if (m_esp_wr) chk("esp_new", esp_new, m_esp_new);
    chk("shutdown",    32'(shutdown),       32'(m_ph == P_SHUT));
  endtask

  // One clock: check outputs, drive inputs for the next edge, advance model.
  task automatic step(input logic ex, input logic [7:0] v, input logic [31:0] e,
                      input logic [31:0] f, input logic [31:0] s, input logic pe,
                      input logic rdy, input logic [31:0] rd);
    logic nxt_wr;
    @(negedge clk);
    compare();
    if (esp_wr) obs_esp_new = esp_new;
    if (redirect_valid) obs_redir = redirect_eip;
    if (mem_valid && rdy) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    exc_valid = ex; exc_vector = v; exc_eip = e; eflags = f; esp = s;
    pipe_empty = pe; mem_ready = rdy; mem_rdata = rd;
    nxt_wr = 1'b0;
    case (m_ph)
      P_IDLE: if (ex) begin
        m_esp = s;
        x_addr[0] = s - 32'd4;      x_data[0] = f;     x_we[0] = 1'b1;
        x_addr[1] = s - 32'd8;      x_data[1] = e;     x_we[1] = 1'b1;
        x_addr[2] = 32'(v) * 32'd4; x_data[2] = 32'd0; x_we[2] = 1'b0;
        m_ph = P_FLUSH;
      end
      P_FLUSH: m_ph = P_DRAIN;
      P_DRAIN: if (pe) begin m_ph = P_XFER; m_idx = 0; end
      P_XFER: begin
`ifdef DOUBLE_FAULT_EN
        if (ex) m_ph = P_SHUT;
        else
`endif
        if (rdy) begin
          if (m_idx == 1) begin nxt_wr = 1'b1; m_esp_new = m_esp - 32'd8; end
          if (m_idx == 2) begin m_word = rd; m_ph = P_REDIR; m_idx = 0; end
          else m_idx++;
        end
      end
      P_REDIR: m_ph = P_IDLE;
      default: ;
    endcase
    m_esp_wr = nxt_wr;
  endtask

  task automatic tick(input logic pe, input logic rdy, input logic [31:0] rd);
    step(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, pe, rdy, rd);
  endtask

  task automatic raise(input logic [7:0] v, input logic [31:0] e,
                       input logic [31:0] f, input logic [31:0] s);
    step(1'b1, v, e, f, s, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".stall"}, 32'(stall_fetch), 32'd0);
    chk({tag, ".flush"}, 32'(flush), 32'd0);
    chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".esp_wr"}, 32'(esp_wr), 32'd0);
    chk({tag, ".esp_new"}, esp_new, 32'd0);
    chk({tag, ".redir_v"}, 32'(redirect_valid), 32'd0);
    chk({tag, ".redir_eip"}, redirect_eip, 32'd0);
    chk({tag, ".shutdown"}, 32'(shutdown), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    compare();
    #1 reset = 1'b0; exc_valid = 1'b0; mem_ready = 1'b0;
    #1 zero_checks("async_rst");
    m_ph = P_IDLE; m_idx = 0; m_esp_wr = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete();
    obs_esp_new = 32'hDEAD_BEEF; obs_redir = 32'hDEAD_BEEF;
  endtask

  initial begin
    reset = 1'b0; exc_valid = 1'b0; exc_vector = '0; exc_eip = '0;
    eflags = '0; esp = '0; pipe_empty = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    m_ph = P_IDLE; m_idx = 0; m_esp_wr = 1'b0; m_esp = '0; m_esp_new = '0; m_word = '0;
    for (int i = 0; i < 3; i++) begin x_addr[i] = '0; x_data[i] = '0; x_we[i] = 1'b0; end
    #12 zero_checks("reset");
    @(negedge clk); #1 reset = 1'b1;

    // Basic sequence: vector 0x0D, esp 0x8000.
    clear_logs();
    raise(8'h0D, 32'h0000_1234, 32'h0000_0202, 32'h0000_8000);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 32'hCAFE_0000);
    chk("basic.n_xfer", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("basic.addr0", log_addr[0], 32'h0000_7FFC);
      chk("basic.data0", log_data[0], 32'h0000_0202);
      chk("basic.addr1", log_addr[1], 32'h0000_7FF8);
      chk("basic.data1", log_data[1], 32'h0000_1234);
      chk("basic.addr2", log_addr[2], 32'h0000_0034);
    end
    chk("basic.esp_new", obs_esp_new, 32'h0000_7FF8);
    chk("basic.redir", obs_redir, 32'hCAFE_0000);

    // mem_ready low for 5 cycles in PUSH_FLAGS.
    raise(8'h02, 32'h0000_4000, 32'h0000_0246, 32'h0001_0000);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 32'd0);
      @(posedge clk); #1;
      chk("stall.addr", mem_addr, 32'h0000_FFFC);
      chk("stall.wdata", mem_wdata, 32'h0000_0246);
      chk("stall.valid", 32'(mem_valid), 32'd1);
    end
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 32'h0000_0100);

    // pipe_empty low 10 cycles after FLUSH.
    raise(8'h03, 32'h0000_0010, 32'h0000_0001, 32'h0000_3000);
    tick(1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 32'd0);
      @(posedge clk); #1;
      chk("drain.valid", 32'(mem_valid), 32'd0);
    end
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 32'h0000_0200);

    // New fault while pushing EIP.
    clear_logs();
    raise(8'h05, 32'h0000_0020, 32'h0000_0002, 32'h0000_4000);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'd0);
    step(1'b1, 8'h09, 32'h0000_9999, 32'h0, 32'h0000_1000, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
`ifdef DOUBLE_FAULT_EN
    chk("dflt.shutdown", 32'(shutdown), 32'd1);
    chk("dflt.mem_valid", 32'(mem_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 32'h0000_0300);
    chk("dflt.no_redir", obs_redir, 32'hDEAD_BEEF);
    chk("dflt.busy", 32'(busy), 32'd1);
    do_reset();
`else
    chk("dflt.shutdown", 32'(shutdown), 32'd0);
    chk("dflt.addr", mem_addr, 32'h0000_3FF8);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 32'h0000_0300);
    chk("dflt.redir", obs_redir, 32'h0000_0300);
    chk("dflt.esp_new", obs_esp_new, 32'h0000_3FF8);
`endif

    // Reset during READ_VEC, then a normal fault.
    clear_logs();
    raise(8'h07, 32'h0000_0030, 32'h0000_0003, 32'h0000_5000);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'd0);
    tick(1'b1, 1'b1, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    do_reset();
    chk("rst.no_redir", obs_redir, 32'hDEAD_BEEF);
    clear_logs();
    raise(8'h01, 32'h0000_0040, 32'h0000_0004, 32'h0000_2000);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 32'h0000_5555);
    chk("rst.redir", obs_redir, 32'h0000_5555);
    chk("rst.esp_new", obs_esp_new, 32'h0000_1FF8);

    // Stack pointer wrap.
    clear_logs();
    raise(8'hFF, 32'h0000_0050, 32'h0000_0005, 32'h0000_0004);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 32'h0000_0777);
    chk("wrap.n_xfer", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("wrap.addr0", log_addr[0], 32'h0000_0000);
      chk("wrap.addr1", log_addr[1], 32'hFFFF_FFFC);
      chk("wrap.addr2", log_addr[2], 32'h0000_03FC);
    end
    chk("wrap.esp_new", obs_esp_new, 32'hFFFF_FFFC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (m_ph == P_SHUT || $urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 7) == 0, 8'($urandom), $urandom, $urandom,
                $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 SHALL have parameter IDT_BASE, default 32'h0000_0000: base address of the 4-byte-per-entry vector table.
REQ-002 SHALL have parameter PUSH_BYTES, default 4: stack decrement applied per pushed word.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports exc_valid  in  1  limit-check fault raised; exc_vector  in  8  fault vector; exc_eip  in  32  faulting instruction EIP.
REQ-006 SHALL have ports eflags  in  32  current flags; esp  in  32  current stack pointer; pipe_empty  in  1  pipeline drained.
REQ-007 SHALL have ports mem_valid  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_ready  in  1; mem_rdata  in  32.
REQ-008 SHALL have ports flush  out  1; stall_fetch  out  1; esp_wr  out  1; esp_new  out  32; redirect_valid  out  1; redirect_eip  out  32; busy  out  1; shutdown  out  1.

Function
REQ-009 SHALL implement states IDLE, FLUSH, DRAIN, PUSH_FLAGS, PUSH_EIP, READ_VEC, REDIRECT, SHUTDOWN.
REQ-010 In IDLE, exc_valid high at a rising edge SHALL capture exc_vector, exc_eip, eflags, esp and move to FLUSH.
REQ-011 FLUSH SHALL assert flush for exactly one cycle, then move to DRAIN.
REQ-012 DRAIN SHALL wait until pipe_empty is high, then move to PUSH_FLAGS.
REQ-013 PUSH_FLAGS SHALL drive mem_valid=1, mem_we=1, mem_addr=esp_cap-PUSH_BYTES, mem_wdata=eflags_cap, held stable until mem_ready.
REQ-014 PUSH_EIP SHALL drive mem_valid=1, mem_we=1, mem_addr=esp_cap-2*PUSH_BYTES, mem_wdata=eip_cap, held stable until mem_ready.
REQ-015 READ_VEC SHALL drive mem_valid=1, mem_we=0, mem_addr=IDT_BASE+{22'b0,vector_cap,2'b00}, latching mem_rdata on mem_ready.
REQ-016 A transfer SHALL complete only in a cycle with mem_valid and mem_ready both high; the state advances on that edge.
REQ-017 On PUSH_EIP completion esp_wr SHALL pulse one cycle with esp_new=esp_cap-2*PUSH_BYTES.
REQ-018 REDIRECT SHALL assert redirect_valid for one cycle with redirect_eip=latched vector word, then return to IDLE.
REQ-019 stall_fetch and busy SHALL be high in every state except IDLE; busy SHALL also be high in SHUTDOWN.
REQ-020 Address arithmetic SHALL be 32-bit modulo 2^32; esp below 8 wraps without special handling.
REQ-021 exc_valid while busy and not in SHUTDOWN SHALL be ignored when DOUBLE_FAULT_EN is undefined.
REQ-022 SHUTDOWN SHALL hold shutdown=1, stall_fetch=1, all memory outputs low, until reset.
REQ-023 mem_ready in a cycle with mem_valid low SHALL have no effect.

Reset
REQ-024 Reset low SHALL asynchronously force IDLE and all outputs and captured registers to 0.
REQ-025 Reset mid-transfer SHALL drop mem_valid immediately; no esp_wr or redirect_valid SHALL follow.

Configuration
REQ-026 With DOUBLE_FAULT_EN defined, exc_valid in PUSH_FLAGS, PUSH_EIP or READ_VEC SHALL abort the transfer and enter SHUTDOWN next cycle.
REQ-027 Without DOUBLE_FAULT_EN, SHUTDOWN SHALL be unreachable and shutdown SHALL be tied 0.

Structure
REQ-028 State encoding (3-bit) and vector-entry size constant SHALL reside in the shared package.
REQ-029 One sub-module, exc_capture_regs, SHALL hold the four captured registers with load enable.

Verification
REQ-030 exc_valid, vector 8'h0D, eip 32'h0000_1234, esp 32'h0000_8000, pipe_empty=1, mem_ready=1 -> writes to 32'h7FFC then 32'h7FF8, read 32'h0000_0034, redirect_eip=read data, esp_new=32'h7FF8.
REQ-031 mem_ready held low 5 cycles in PUSH_FLAGS -> mem_addr/mem_wdata stable, no state change.
REQ-032 pipe_empty low 10 cycles after FLUSH -> no mem_valid until pipe_empty high.
REQ-033 DOUBLE_FAULT_EN defined, exc_valid during PUSH_EIP -> shutdown=1 next cycle, no redirect_valid; undefined -> ignored, normal redirect.
REQ-034 reset low during READ_VEC -> all outputs 0 asynchronously, busy=0, next exc_valid processed normally.
REQ-035 esp 32'h0000_0004 -> writes to 32'h0000_0000 and 32'hFFFF_FFFC, esp_new 32'hFFFF_FFFC.
